// File: rtl/pfc_pkg.sv
// Shared types and helpers for the serial parity frame checker.
package pfc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } pfc_state_t;

    // Bit counter must reach DATA_W, the index of the parity beat.
    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/pfc_out_reg.sv
// Single-entry valid/ready holding register with parity-error counter and
// sticky overflow flag for frames that arrive while the entry is blocked.
module pfc_out_reg
    import pfc_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_perr,
    input  logic              out_ready,
    input  logic              stat_clr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              overflow
);

    logic accept;
    logic drop;

    // A new word may enter when the entry is empty or is being drained this cycle.
    assign accept = load_valid && (!out_valid || out_ready);
    assign drop   = load_valid && out_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_perr  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_perr  <= load_perr;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // stat_clr beats a same-cycle increment or overflow set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt  <= '0;
            overflow <= 1'b0;
        end else if (stat_clr) begin
            err_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept && load_perr && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/parity_frame_checker.sv
// Deserialises LSB-first frames of DATA_W data bits plus one parity bit and
// presents each word with its parity-error flag on a valid/ready output.
module parity_frame_checker
    import pfc_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter bit ODD    = 1'b0,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin_valid,
    input  logic              sin_start,
    input  logic              sin_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              overflow,
    input  logic              stat_clr,
    output logic              dbg_state
);

    // Handshake: a word transfers on any rising edge where out_valid && out_ready;
    // out_data/out_perr are stable while out_valid is high and not accepted.

    localparam int              BCW      = bit_cnt_w(DATA_W);
    localparam logic [BCW-1:0]  LAST_IDX = BCW'(DATA_W);

    pfc_state_t        state_q, state_d;
    logic [BCW-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              xor_q, xor_d;
    logic              frame_done;
    logic              frame_perr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            xor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            xor_q   <= xor_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        xor_d      = xor_q;
        frame_done = 1'b0;
        frame_perr = 1'b0;
        if (sin_valid) begin
            // A start beat always wins, silently discarding any partial frame.
            if (sin_start) begin
                shreg_d    = '0;
                shreg_d[0] = sin_bit;
                xor_d      = sin_bit;
                cnt_d      = BCW'(1);
                state_d    = SHIFT;
            end else if (state_q == SHIFT) begin
                if (cnt_q == LAST_IDX) begin
                    frame_done = 1'b1;
                    frame_perr = xor_q ^ sin_bit ^ ODD;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end else begin
                    shreg_d[cnt_q] = sin_bit;
                    xor_d          = xor_q ^ sin_bit;
                    cnt_d          = cnt_q + 1'b1;
                end
            end
        end
    end

    assign dbg_state = state_q;

    pfc_out_reg #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(frame_done),
        .load_data (shreg_q),
        .load_perr (frame_perr),
        .out_ready (out_ready),
        .stat_clr  (stat_clr),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_perr  (out_perr),
        .err_cnt   (err_cnt),
        .overflow  (overflow)
    );

endmodule
